// File: rtl/pwm_pkg.sv
// Shared widths, defaults and FSM state type for the PWM capture block.
package pwm_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
    localparam int unsigned DUTY_W         = 10;
    localparam int unsigned CNT_W          = 32;
    localparam int unsigned DIV_W          = 42;

    typedef enum logic [1:0] {
        StArm,
        StRun,
        StDivFreq,
        StDivDuty
    } state_e;

endpackage

// File: rtl/pwm_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A start pulse performs the first step in the same cycle, so a full divide
// takes DIV_W cycles and done pulses the cycle after the last step.
// Asserting start while a divide is running restarts it.
module pwm_divider
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] rem_src;
    logic [DIV_W-1:0] quo_src;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   trial_sub;

    // One shift-and-subtract step; start seeds the step from the new operands
    always_comb begin
        rem_src   = start ? '0 : rem_q;
        quo_src   = start ? dividend : quo_q;
        trial     = {rem_src, quo_src[DIV_W-1]};
        trial_sub = trial - {1'b0, divisor};
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (start || cnt_q != 6'd0) begin
            if (trial >= {1'b0, divisor}) begin
                rem_d = trial_sub[CNT_W-1:0];
                quo_d = {quo_src[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = trial[CNT_W-1:0];
                quo_d = {quo_src[DIV_W-2:0], 1'b0};
            end
            cnt_d  = start ? 6'(DIV_W - 1) : cnt_q - 6'd1;
            done_d = (cnt_d == 6'd0);
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM frequency (Hz) and duty (1/1024 steps) with one shared divider,
// and flags a line stuck high or low.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ         = CLK_HZ_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  freq,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              busy,
    output logic              stuck_high,
    output logic              stuck_low
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x >= TMO) ? TMO : x + 1'b1;
    endfunction

    logic sync1, sync2, sync3;
    logic rise_det, any_edge, timeout;

    logic [CNT_W-1:0] period_cnt, high_cnt, hold_cnt;
    logic [CNT_W-1:0] period_lat, high_lat, freq_tmp;
    logic             kick_q;

    state_e state_q, state_d;

    logic             div_start, div_done, freq_done, result_done;
    logic [DIV_W-1:0] div_dividend, div_quotient;

    // Synchronizer plus edge-detect stage; no reset so a line held high
    // through reset does not fake a rising edge afterwards
    always_ff @(posedge clk) begin
        sync1 <= pwm_in;
        sync2 <= sync1;
        sync3 <= sync2;
    end

    assign rise_det = sync2 & ~sync3;
    assign any_edge = sync2 ^ sync3;
    // Fires once: hold_cnt saturates at TMO and never revisits TMO-1
    assign timeout  = !any_edge && (hold_cnt == TMO - 1'b1);

    // Period, high-time and level-hold counters, all saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            period_cnt <= rise_det ? CNT_W'(1) : sat_inc(period_cnt);
            high_cnt   <= rise_det ? CNT_W'(1) : (sync2 ? sat_inc(high_cnt) : high_cnt);
            hold_cnt   <= any_edge ? CNT_W'(1) : sat_inc(hold_cnt);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StArm;
        else       state_q <= state_d;
    end

    // Next-state logic; timeout aborts from any state
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StArm;
        end else begin
            case (state_q)
                StArm:     if (rise_det) state_d = StRun;
                StRun:     if (rise_det) state_d = StDivFreq;
                StDivFreq: if (freq_done) state_d = StDivDuty;
                StDivDuty: if (div_done) state_d = StRun;
                default:   state_d = StArm;
            endcase
        end
    end

    // FSM outputs and divider operand selection
    always_comb begin
        busy = (state_q == StDivFreq) || (state_q == StDivDuty);
        // kick_q masks a stale done left over from an aborted divide
        freq_done    = (state_q == StDivFreq) && div_done && !kick_q;
        result_done  = (state_q == StDivDuty) && div_done;
        div_start    = kick_q || freq_done;
        div_dividend = kick_q ? DIV_W'(CLK_HZ) : {high_lat, {DUTY_W{1'b0}}};
    end

    // Operand latch at the starting edge and intermediate frequency result
    always_ff @(posedge clk) begin
        if (reset) begin
            kick_q     <= 1'b0;
            period_lat <= '0;
            high_lat   <= '0;
            freq_tmp   <= '0;
        end else begin
            kick_q <= (state_q == StRun) && rise_det;
            if ((state_q == StRun) && rise_det) begin
                period_lat <= period_cnt;
                high_lat   <= high_cnt;
            end
            if (freq_done) freq_tmp <= div_quotient[CNT_W-1:0];
        end
    end

    pwm_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (period_lat),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Published results, valid pulse and stuck flags
    always_ff @(posedge clk) begin
        if (reset) begin
            freq       <= '0;
            duty       <= '0;
            valid      <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timeout) begin
                valid <= 1'b1;
                freq  <= '0;
                if (sync2) begin
                    stuck_high <= 1'b1;
                    duty       <= {DUTY_W{1'b1}};
                end else begin
                    stuck_low <= 1'b1;
                    duty      <= '0;
                end
            end else begin
                if (any_edge) begin
                    stuck_high <= 1'b0;
                    stuck_low  <= 1'b0;
                end
                if (result_done) begin
                    valid <= 1'b1;
                    freq  <= freq_tmp;
                    duty  <= (|div_quotient[DIV_W-1:DUTY_W]) ? {DUTY_W{1'b1}}
                                                             : div_quotient[DUTY_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT_CYCLES = 1000.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [31:0] freq;
    logic [9:0]  duty;
    logic        valid, busy, stuck_high, stuck_low;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int k;

    int rise_q[$];
    int valid_q[$];
    int freq_q[$];
    int duty_q[$];
    int vbusy_q[$];
    int busy_q[$];
    logic busy_prev = 1'b0;

    pwm_capture #(
        .CLK_HZ         (100_000_000),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .freq       (freq),
        .duty       (duty),
        .valid      (valid),
        .busy       (busy),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result and the start of every busy window
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_q.push_back(cyc);
            freq_q.push_back(int'(freq));
            duty_q.push_back(int'(duty));
            vbusy_q.push_back(int'(busy));
        end
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_q.push_back(cyc);
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rise_q.delete();
        valid_q.delete();
        freq_q.delete();
        duty_q.delete();
        vbusy_q.delete();
        busy_q.delete();
    endtask

    // n periods of hi cycles high then lo cycles low, rising edge first
    task automatic pwm(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 pwm_in = 1'b1;
            rise_q.push_back(cyc);
            repeat (hi) @(posedge clk);
            #1 pwm_in = 1'b0;
            repeat (lo - 1) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_freq", freq, 0);
        check("rst_duty", duty, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stuck_hi", stuck_high, 0);
        check("rst_stuck_lo", stuck_low, 0);

        // 25/75 at period 100: first edge arms, second starts the divide
        clear_logs();
        pwm(25, 75, 4);
        check("a_count", valid_q.size(), 3);
        check("a_latency", valid_q[0], rise_q[1] + 88);
        check("a_busy_start", busy_q[0], rise_q[1] + 3);
        check("a_busy_at_valid", vbusy_q[0], 0);
        check("a_freq", freq_q[0], 1_000_000);
        check("a_duty", duty_q[0], 256);

        // 1 high / 999 low
        clear_logs();
        pwm(1, 999, 3);
        check("b_count", valid_q.size(), 3);
        check("b_freq", freq_q[2], 100_000);
        check("b_duty", duty_q[2], 1);

        // 999 high / 1 low
        clear_logs();
        pwm(999, 1, 3);
        check("b2_count", valid_q.size(), 3);
        check("b2_duty", duty_q[1], 1022);
        check("b2_freq", freq_q[2], 100_000);

        // period 20: one result per five periods
        clear_logs();
        pwm(5, 15, 30);
        check("c_count", valid_q.size(), 6);
        check("c_first", valid_q[0], rise_q[0] + 88);
        check("c_gap_first", valid_q[1] - valid_q[0], 100);
        check("c_gap_last", valid_q[5] - valid_q[4], 100);
        check("c_duty_1", duty_q[1], 256);
        check("c_freq", freq_q[5], 5_000_000);
        check("c_duty", duty_q[5], 256);

        // held high: one measured result, then exactly one stuck result
        clear_logs();
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (1300) @(posedge clk);
        #1;
        check("d_count", valid_q.size(), 2);
        check("d_meas_freq", freq_q[0], 5_000_000);
        check("d_stuck_freq", freq_q[1], 0);
        check("d_stuck_duty", duty_q[1], 1023);
        check("d_stuck_hi", stuck_high, 1);
        check("d_stuck_lo", stuck_low, 0);
        check("d_out_duty", duty, 1023);

        // resume 50/50 at period 200
        clear_logs();
        @(posedge clk); #1 pwm_in = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("e_flag_clear", stuck_high, 0);
        pwm(100, 100, 3);
        check("e_count", valid_q.size(), 2);
        check("e_latency", valid_q[0], rise_q[1] + 88);
        check("e_freq", freq_q[0], 500_000);
        check("e_duty", duty_q[0], 512);

        // reset at E+40 aborts the divide
        clear_logs();
        @(posedge clk); #1 pwm_in = 1'b1;
        k = cyc;
        repeat (42) @(posedge clk);
        #1;
        check("r_busy_before", busy, 1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("r_freq", freq, 0);
        check("r_duty", duty, 0);
        check("r_valid", valid, 0);
        check("r_busy", busy, 0);
        check("r_stuck", {stuck_high, stuck_low}, 0);
        while (cyc < k + 100) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (99) @(posedge clk);
        check("r_no_valid", valid_q.size(), 0);
        pwm(100, 100, 3);
        check("r_count", valid_q.size(), 2);
        check("r_latency", valid_q[0], rise_q[1] + 88);
        check("r_freq_after", freq_q[0], 500_000);

        // 25/75 then 75/25 at period 100 with no gap
        clear_logs();
        pwm(25, 75, 4);
        pwm(75, 25, 4);
        check("f_count", valid_q.size(), 8);
        check("f_duty_3", duty_q[3], 256);
        check("f_duty_4", duty_q[4], 256);
        check("f_duty_5", duty_q[5], 768);
        check("f_freq_5", freq_q[5], 1_000_000);
        check("f_duty_7", duty_q[7], 768);
        check("f_freq_7", freq_q[7], 1_000_000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
